// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite types, response constants and slave state encoding.
package ahb_lite_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'b000,
      HSIZE_HALF = 3'b001,
      HSIZE_WORD = 3'b010
   } hsize_t;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } slave_state_t;

   // Little-endian byte-lane enables for an aligned transfer.
   function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] lane);
      logic [3:0] strb;
      case (size)
         HSIZE_BYTE: strb = 4'b0001 << lane;
         HSIZE_HALF: strb = lane[1] ? 4'b1100 : 4'b0011;
         default:    strb = 4'b1111;
      endcase
      return strb;
   endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM with per-byte write enables, synchronous write, combinational read.
module ahb_sram_array #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned IDX_W = 8
) (
   input  logic             clk,
   input  logic [IDX_W-1:0] idx,
   input  logic [3:0]       we,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) begin
            mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem_q[idx];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: captures the address phase, inserts wait states,
// and gives the two-cycle ERROR response to illegal transfers.
module ahb_lite_sram_slave
   import ahb_lite_pkg::*;
#(
   parameter int unsigned MEM_DEPTH   = 256,
   parameter int unsigned HADDR_SIZE  = 16,
   parameter int unsigned HDATA_SIZE  = 32,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [HADDR_SIZE-1:0] HADDR,
   input  logic [HDATA_SIZE-1:0] HWDATA,
   output logic [HDATA_SIZE-1:0] HRDATA,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [1:0]            HTRANS,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP
);

   localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned CNT_W = 4;

   slave_state_t          state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [HADDR_SIZE-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [2:0]            size_q, size_d;
   logic                  hreadyout_q, hreadyout_d;
   logic                  hresp_q, hresp_d;

   logic                  accept_c;
   logic                  err_c;
   logic [3:0]            we_c;
   logic [31:0]           rdata_c;
   logic                  unused_c;

   assign accept_c = HSEL & HREADY & HTRANS[1];
   assign err_c    = (32'(HADDR[HADDR_SIZE-1:2]) >= MEM_DEPTH)
                   | (HSIZE > HSIZE_WORD)
                   | ((HSIZE == HSIZE_HALF) & HADDR[0])
                   | ((HSIZE == HSIZE_WORD) & (HADDR[1:0] != 2'b00));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      size_d  = size_q;
      case (state_q)
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_DATA;
         end
         ST_ERR1: state_d = ST_ERR2;
         default: begin
            // Ready states: a new address phase may be taken here.
            if (accept_c) begin
               addr_d  = HADDR;
               write_d = HWRITE;
               size_d  = HSIZE;
               if (err_c) begin
                  state_d = ST_ERR1;
               end else if (WAIT_STATES == 0) begin
                  state_d = ST_DATA;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_W'(WAIT_STATES);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
      hreadyout_d = (state_d != ST_WAIT) && (state_d != ST_ERR1);
      hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         write_q     <= 1'b0;
         size_q      <= '0;
         hreadyout_q <= 1'b1;
         hresp_q     <= HRESP_OKAY;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         write_q     <= write_d;
         size_q      <= size_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
      end
   end

   // Write lands on the edge closing DATA; a reset on that edge cancels it.
   assign we_c = (state_q == ST_DATA && write_q && !HRESET) ? byte_strobe(size_q, addr_q[1:0]) : 4'b0000;

   ahb_sram_array #(
      .DEPTH (MEM_DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (HCLK),
      .idx   (addr_q[IDX_W+1:2]),
      .we    (we_c),
      .wdata (HWDATA[31:0]),
      .rdata (rdata_c)
   );

   assign HRDATA    = (state_q == ST_DATA && !write_q) ? HDATA_SIZE'(rdata_c) : '0;
   assign HREADYOUT = hreadyout_q;
   assign HRESP     = hresp_q;

   assign unused_c = ^{HBURST, HPROT, addr_q};

endmodule
